// File: rtl/dds_cmd_parser.sv
// Framed command decoder feeding the DDS parameter bus. Parameters update
// atomically only after the whole frame (checksum and range) has been validated.
module dds_cmd_parser #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [23:0] DEF_FC      = 24'd100000,
  parameter logic [23:0] DEF_FS      = 24'd1000,
  parameter logic [3:0]  DEF_MA      = 4'd5,
  parameter logic [15:0] DEF_FD      = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [2:0]  mode,
  output logic [23:0] fc,
  output logic [23:0] fs,
  output logic [3:0]  ma,
  output logic [15:0] fd,
  output logic        upd,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_PAYLOAD, S_CHK} state_e;

  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [1:0]  len_q, len_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  xor_q, xor_d;
  logic [23:0] shadow_q, shadow_d;
  logic [23:0] tmo_q, tmo_d;
  logic [2:0]  mode_q, mode_d;
  logic [23:0] fc_q, fc_d, fs_q, fs_d;
  logic [3:0]  ma_q, ma_d;
  logic [15:0] fd_q, fd_d;
  logic        upd_q, upd_d, err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    xor_d      = xor_q;
    shadow_d   = shadow_q;
    tmo_d      = '0;
    mode_d     = mode_q;
    fc_d       = fc_q;
    fs_d       = fs_q;
    ma_d       = ma_q;
    fd_d       = fd_q;
    upd_d      = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    if (state_q != S_IDLE && !rx_valid) tmo_d = tmo_q + 24'd1;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == HEADER) state_d = S_CMD;
      end
      S_CMD: begin
        if (rx_valid) begin
          cmd_d    = rx_data[2:0];
          xor_d    = rx_data;
          shadow_d = '0;
          cnt_d    = '0;
          state_d  = S_PAYLOAD;
          unique case (rx_data)
            8'h01, 8'h04: len_d = 2'd1;
            8'h02, 8'h03: len_d = 2'd3;
            8'h05:        len_d = 2'd2;
            default: begin
              err_d      = 1'b1;
              err_code_d = 2'd2;
              state_d    = S_IDLE;
            end
          endcase
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          shadow_d = {shadow_q[15:0], rx_data};
          xor_d    = xor_q ^ rx_data;
          cnt_d    = cnt_q + 2'd1;
          if (cnt_q + 2'd1 == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          state_d = S_IDLE;
          if (rx_data != xor_q) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else begin
            upd_d = 1'b1;
            unique case (cmd_q)
              3'd1: if (shadow_q[2:0] > 3'd4) begin
                      upd_d = 1'b0; err_d = 1'b1; err_code_d = 2'd2;
                    end else mode_d = shadow_q[2:0];
              3'd2: fc_d = shadow_q;
              3'd3: fs_d = shadow_q;
              3'd4: if (shadow_q[3:0] > 4'd10) begin
                      upd_d = 1'b0; err_d = 1'b1; err_code_d = 2'd2;
                    end else ma_d = shadow_q[3:0];
              default: fd_d = shadow_q[15:0];
            endcase
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte arriving on the expiry cycle is still accepted; only true silence times out.
    if (state_q != S_IDLE && !rx_valid && tmo_q == TMO_LAST) begin
      state_d    = S_IDLE;
      tmo_d      = '0;
      err_d      = 1'b1;
      err_code_d = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      xor_q      <= '0;
      shadow_q   <= '0;
      tmo_q      <= '0;
      mode_q     <= '0;
      fc_q       <= DEF_FC;
      fs_q       <= DEF_FS;
      ma_q       <= DEF_MA;
      fd_q       <= DEF_FD;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      xor_q      <= xor_d;
      shadow_q   <= shadow_d;
      tmo_q      <= tmo_d;
      mode_q     <= mode_d;
      fc_q       <= fc_d;
      fs_q       <= fs_d;
      ma_q       <= ma_d;
      fd_q       <= fd_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign mode     = mode_q;
  assign fc       = fc_q;
  assign fs       = fs_q;
  assign ma       = ma_q;
  assign fd       = fd_q;
  assign upd      = upd_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Directed bench for dds_cmd_parser: frames, checksum/range/timeout errors,
// async reset mid-frame and boundary values, all against hand-computed values.
module tb_dds_cmd_parser;

  localparam int unsigned TMO = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [2:0]  mode;
  logic [23:0] fc, fs;
  logic [3:0]  ma;
  logic [15:0] fd;
  logic        upd, err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0, err_cnt = 0, both_cnt = 0;
  int u0, e0, n;

  dds_cmd_parser #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .mode(mode), .fc(fc), .fs(fs), .ma(ma), .fd(fd),
    .upd(upd), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Pulses are tallied one edge after they appear.
  always @(posedge clk) begin
    if (upd === 1'b1) upd_cnt++;
    if (err === 1'b1) err_cnt++;
    if (upd === 1'b1 && err === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_fc", 32'(fc), 32'd100000);
    check("rst_fs", 32'(fs), 32'd1000);
    check("rst_ma", 32'(ma), 32'd5);
    check("rst_fd", 32'(fd), 32'd1000);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);

    // fc frame on consecutive cycles; upd visible right after the CHK edge
    send(8'hA5); send(8'h02); send(8'h01); send(8'h86); send(8'hA0); send(8'h25);
    check("fc_upd", 32'(upd), 32'd1);
    check("fc_err", 32'(err), 32'd0);
    check("fc_val", 32'(fc), 32'h0186A0);
    idle(1);
    check("fc_upd_pulse", 32'(upd), 32'd0);
    check("fc_mode_hold", 32'(mode), 32'd0);
    check("fc_fs_hold", 32'(fs), 32'd1000);
    check("fc_ma_hold", 32'(ma), 32'd5);
    check("fc_fd_hold", 32'(fd), 32'd1000);

    // back-to-back mode and fd frames
    u0 = upd_cnt; e0 = err_cnt;
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
    send(8'hA5); send(8'h05); send(8'h13); send(8'h88); send(8'h9E);
    idle(2);
    check("b2b_mode", 32'(mode), 32'd2);
    check("b2b_fd", 32'(fd), 32'd5000);
    check("b2b_upds", 32'(upd_cnt - u0), 32'd2);
    check("b2b_errs", 32'(err_cnt - e0), 32'd0);

    // bad checksum
    send(8'hA5); send(8'h01); send(8'h02); send(8'h00);
    check("chk_err", 32'(err), 32'd1);
    check("chk_code", 32'(err_code), 32'd1);
    check("chk_upd", 32'(upd), 32'd0);
    idle(1);
    check("chk_err_pulse", 32'(err), 32'd0);
    check("chk_code_held", 32'(err_code), 32'd1);
    check("chk_mode_hold", 32'(mode), 32'd2);

    // mode out of range (valid checksum 01^05=04)
    send(8'hA5); send(8'h01); send(8'h05); send(8'h04);
    check("rng_err", 32'(err), 32'd1);
    check("rng_code", 32'(err_code), 32'd2);
    check("rng_mode_hold", 32'(mode), 32'd2);

    // unknown command rejected at the CMD edge
    send(8'hA5); send(8'h07);
    check("unk_err", 32'(err), 32'd1);
    check("unk_code", 32'(err_code), 32'd2);

    // timeout after partial fc frame
    send(8'hA5); send(8'h02); send(8'h01);
    n = 0;
    while (err !== 1'b1 && n < int'(TMO) + 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(TMO));
    check("tmo_code", 32'(err_code), 32'd3);
    check("tmo_fc_hold", 32'(fc), 32'h0186A0);
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'h56); send(8'h72);
    check("tmo_next_fc", 32'(fc), 32'h123456);

    // garbage then ma frame with spaced strobes (checksum 04^08 = 0C)
    e0 = err_cnt;
    send(8'h00); send(8'hFF); send(8'h3C);
    send(8'hA5); idle(3); send(8'h04); idle(2); send(8'h08); idle(4); send(8'h0C);
    idle(1);
    check("gar_ma", 32'(ma), 32'd8);
    check("gar_errs", 32'(err_cnt - e0), 32'd0);

    // async reset mid-frame
    send(8'hA5); send(8'h04);
    rst_n = 1'b0;
    #1;
    check("arst_ma", 32'(ma), 32'd5);
    check("arst_fc", 32'(fc), 32'd100000);
    check("arst_mode", 32'(mode), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    u0 = upd_cnt; e0 = err_cnt;
    send(8'h08); send(8'h0C);
    idle(2);
    check("arst_ma_after", 32'(ma), 32'd5);
    check("arst_upds", 32'(upd_cnt - u0), 32'd0);
    check("arst_errs", 32'(err_cnt - e0), 32'd0);

    // boundaries: ma=10 ok, ma=11 rejected, mode=4 ok, HEADER bytes as payload
    send(8'hA5); send(8'h04); send(8'h0A); send(8'h0E);
    check("ma10_upd", 32'(upd), 32'd1);
    check("ma10", 32'(ma), 32'd10);
    send(8'hA5); send(8'h04); send(8'h0B); send(8'h0F);
    check("ma11_err", 32'(err), 32'd1);
    check("ma11_code", 32'(err_code), 32'd2);
    check("ma11_hold", 32'(ma), 32'd10);
    send(8'hA5); send(8'h01); send(8'h04); send(8'h05);
    check("mode4", 32'(mode), 32'd4);
    send(8'hA5); send(8'h05); send(8'hA5); send(8'hA5); send(8'h05);
    check("fd_hdr_data", 32'(fd), 32'h00A5A5);
    send(8'hA5); send(8'h03); send(8'h0A); send(8'hBC); send(8'hDE); send(8'h6B);
    check("fs_val", 32'(fs), 32'h0ABCDE);
    idle(2);
    check("upd_err_exclusive", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
